// File: rtl/io_responder_if.sv
// Processor data-memory bus toward the I/O responder; iodata/ioSel return
// combinationally from the target with zero latency and no backpressure.
interface io_responder_if;
  logic        memread;
  logic        memwrite;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [15:0] iodata;
  logic        ioSel;

  modport master (
    output memread, memwrite, adr, writedata,
    input  iodata, ioSel
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output iodata, ioSel
  );
endinterface

// File: rtl/io_responder.sv
// I/O-space target (adr[15:14]==2'b11): LED, synced switches, event FIFO, timer; reads are
// zero-latency, writes/pops land on the edge, never stalls. IO_IRQ_EN adds IRQMASK at offset 6 and a registered irq.
module io_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int EV_WIDTH   = 8,
  parameter int SW_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  io_responder_if.slave       bus,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                evValid,
  input  logic [EV_WIDTH-1:0] evData,
  output logic [15:0]         led
`ifdef IO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [15:0]         led_q, led_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         cmp_q, cmp_d;
  logic                tflag_q, tflag_d;
  logic                ovf_q, ovf_d;
  logic [PW:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]         wr_ptr_q, wr_ptr_d;
  logic [EV_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
`ifdef IO_IRQ_EN
  logic [1:0]          mask_q, mask_d;
  logic                irq_q, irq_d;
`endif

  logic        sel, rd_en, wr_en;
  logic [2:0]  off;
  logic        empty, full, pop, push, ovf_set, tflag_set;
  logic [15:0] rdata;

  assign bus.ioSel = (bus.adr[15:14] == 2'b11);
  assign sel       = bus.ioSel && (bus.adr[13:3] == 11'd0);
  assign off       = bus.adr[2:0];
  assign rd_en     = sel && bus.memread;
  assign wr_en     = sel && bus.memwrite;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[PW] != wr_ptr_q[PW]) && (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);

  assign pop       = rd_en && (off == 3'd3) && !empty;
  assign push      = evValid && (!full || pop);
  assign ovf_set   = evValid && full && !pop;
  assign tflag_set = (count_q == cmp_q);

  always_comb begin
    rdata = 16'h0000;
    if (rd_en) begin
      case (off)
        3'd0: rdata = led_q;
        3'd1: rdata = 16'(sw_sync_q);
        3'd2: rdata = {12'h000, tflag_q, ovf_q, full, empty};
        3'd3: rdata = empty ? 16'h0000 : 16'(mem_q[rd_ptr_q[PW-1:0]]);
        3'd4: rdata = count_q;
        3'd5: rdata = cmp_q;
`ifdef IO_IRQ_EN
        3'd6: rdata = {14'h0000, mask_q};
`endif
        default: rdata = 16'h0000;
      endcase
    end
  end

  assign bus.iodata = rdata;
  assign led        = led_q;

  always_comb begin
    led_d    = led_q;
    count_d  = count_q + 16'd1;
    cmp_d    = cmp_q;
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
`ifdef IO_IRQ_EN
    mask_d   = mask_q;
    irq_d    = (mask_q[0] & tflag_q) | (mask_q[1] & ~empty);
`endif
    if (wr_en) begin
      case (off)
        3'd0: led_d   = bus.writedata;
        3'd4: count_d = bus.writedata;
        3'd5: cmp_d   = bus.writedata;
`ifdef IO_IRQ_EN
        3'd6: mask_d  = bus.writedata[1:0];
`endif
        default: ;
      endcase
    end
    // Set beats a simultaneous write-1-to-clear.
    ovf_d   = ovf_set   | (ovf_q   & ~(wr_en && (off == 3'd2) && bus.writedata[2]));
    tflag_d = tflag_set | (tflag_q & ~(wr_en && (off == 3'd2) && bus.writedata[3]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q     <= 16'h0000;
      count_q   <= 16'h0000;
      cmp_q     <= 16'hFFFF;
      tflag_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
`ifdef IO_IRQ_EN
      mask_q    <= 2'b00;
      irq_q     <= 1'b0;
`endif
    end else begin
      led_q     <= led_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      tflag_q   <= tflag_d;
      ovf_q     <= ovf_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
`ifdef IO_IRQ_EN
      mask_q    <= mask_d;
      irq_q     <= irq_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= evData;
    end
  end

`ifdef IO_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Directed test-plan sequence followed by randomized traffic, all checked every cycle against a queue-based model.
module tb_io_responder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] sw;
  logic        evValid;
  logic [7:0]  evData;
  logic [15:0] led;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  io_responder_if bus();

  io_responder #(.FIFO_DEPTH(DEPTH), .EV_WIDTH(8), .SW_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw      (sw),
    .evValid (evValid),
    .evData  (evData),
    .led     (led)
`ifdef IO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain registers, a queue for the FIFO, and a 2-deep sample history for the switches.
  logic [15:0] m_led, m_count, m_cmp;
  bit          m_tflag, m_ovf;
  logic [7:0]  m_q[$];
  logic [15:0] m_sw_hist[$];
  logic [1:0]  m_mask;
  bit          m_irq;

  function automatic logic [15:0] model_read();
    logic [15:0] r;
    r = 16'h0000;
    if (bus.adr[15:14] == 2'b11 && bus.adr[13:3] == 11'd0 && bus.memread) begin
      case (bus.adr[2:0])
        3'd0: r = m_led;
        3'd1: r = m_sw_hist[0];
        3'd2: r = {12'h000, m_tflag, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
        3'd3: r = (m_q.size() == 0) ? 16'h0000 : {8'h00, m_q[0]};
        3'd4: r = m_count;
        3'd5: r = m_cmp;
`ifdef IO_IRQ_EN
        3'd6: r = {14'h0000, m_mask};
`endif
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit sel, rd, wr, pop, was_full, was_empty, ovf_set, tset, clr_o, clr_t;
    logic [2:0] off;
    if (!rst) begin
      m_led = 16'h0000; m_count = 16'h0000; m_cmp = 16'hFFFF;
      m_tflag = 0; m_ovf = 0; m_q.delete(); m_mask = 2'b00; m_irq = 0;
      m_sw_hist.delete(); m_sw_hist.push_back(16'h0000); m_sw_hist.push_back(16'h0000);
    end else begin
      sel = (bus.adr[15:14] == 2'b11) && (bus.adr[13:3] == 11'd0);
      off = bus.adr[2:0];
      rd = sel && bus.memread;
      wr = sel && bus.memwrite;
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      pop = rd && off == 3'd3 && !was_empty;
      ovf_set = evValid && was_full && !pop;
      tset = (m_count == m_cmp);
      m_irq = (m_mask[0] && m_tflag) || (m_mask[1] && !was_empty);
      if (pop) void'(m_q.pop_front());
      if (evValid && (!was_full || pop)) m_q.push_back(evData);
      clr_o = wr && off == 3'd2 && bus.writedata[2];
      clr_t = wr && off == 3'd2 && bus.writedata[3];
      m_ovf   = ovf_set || (m_ovf && !clr_o);
      m_tflag = tset || (m_tflag && !clr_t);
      m_count = (wr && off == 3'd4) ? bus.writedata : m_count + 16'd1;
      if (wr && off == 3'd0) m_led = bus.writedata;
      if (wr && off == 3'd5) m_cmp = bus.writedata;
`ifdef IO_IRQ_EN
      if (wr && off == 3'd6) m_mask = bus.writedata[1:0];
`endif
      m_sw_hist.push_back(sw);
      void'(m_sw_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ioSel", {15'h0000, bus.ioSel}, {15'h0000, bus.adr[15:14] == 2'b11});
      check("iodata", bus.iodata, model_read());
      check("led", led, m_led);
`ifdef IO_IRQ_EN
      check("irq", {15'h0000, irq}, {15'h0000, m_irq});
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic io_read(input logic [15:0] a, input logic [15:0] exp, input string name);
    bus.adr = a; bus.memread = 1'b1; bus.memwrite = 1'b0;
    @(negedge clk);
    check(name, bus.iodata, exp);
    step();
    bus.memread = 1'b0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    bus.adr = a; bus.writedata = d; bus.memwrite = 1'b1; bus.memread = 1'b0;
    step();
    bus.memwrite = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    evValid = 1'b1; evData = d;
    step();
    evValid = 1'b0;
  endtask

  initial begin
    logic [7:0] pat [4];
    rst = 1'b0; sw = 16'h0000; evValid = 1'b0; evData = 8'h00;
    bus.memread = 1'b0; bus.memwrite = 1'b0; bus.adr = 16'h0000; bus.writedata = 16'h0000;
    step(); step();
    rst = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_led", led, 16'h0000);
    step();
    io_read(16'hC000, 16'h0000, "reset_led_rd");
    io_read(16'hC002, 16'h0001, "reset_status");
    io_read(16'hC005, 16'hFFFF, "reset_compare");

    io_write(16'hC000, 16'hA5A5);
    io_read(16'hC000, 16'hA5A5, "led_rd");
    check("led_port", led, 16'hA5A5);
    bus.adr = 16'h8000; bus.memread = 1'b1;
    @(negedge clk);
    check("iosel_8000", {15'h0000, bus.ioSel}, 16'h0000);
    check("iodata_8000", bus.iodata, 16'h0000);
    step();
    bus.memread = 1'b0;

    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    io_read(16'hC002, 16'h0006, "status_full_ovf");
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) io_read(16'hC003, {8'h00, pat[i]}, "event_pop");
    io_read(16'hC002, 16'h0005, "status_empty_ovf");
    io_read(16'hC003, 16'h0000, "event_empty");
    io_read(16'hC002, 16'h0005, "status_after_empty_pop");
    io_write(16'hC002, 16'h0004);
    io_read(16'hC002, 16'h0001, "ovf_cleared");

    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    evValid = 1'b1; evData = 8'h66;
    io_read(16'hC003, 16'h0001, "pop_push_full");
    evValid = 1'b0;
    io_read(16'hC002, 16'h0002, "status_full_no_ovf");
    pat[0] = 8'h02; pat[1] = 8'h03; pat[2] = 8'h04; pat[3] = 8'h66;
    for (int i = 0; i < 4; i++) io_read(16'hC003, {8'h00, pat[i]}, "event_pop2");
    io_read(16'hC002, 16'h0001, "status_empty2");

    io_write(16'hC004, 16'hFFFE);
    io_write(16'hC005, 16'h0001);
    step(); step();
    io_read(16'hC002, 16'h0001, "tflag_before");
    io_read(16'hC002, 16'h0009, "tflag_set");
    io_write(16'hC002, 16'h0008);
    io_read(16'hC002, 16'h0001, "tflag_cleared");
    io_write(16'hC004, 16'h0001);
    io_write(16'hC002, 16'h0008);
    io_read(16'hC002, 16'h0009, "tflag_set_wins");

    sw = 16'h1234;
    io_read(16'hC001, 16'h0000, "sw_old0");
    io_read(16'hC001, 16'h0000, "sw_old1");
    io_read(16'hC001, 16'h1234, "sw_new");

    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 299) != 0);
      bus.memread  = 1'($urandom_range(0, 1));
      bus.memwrite = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 8)       bus.adr = 16'hC000 | 16'(r);
      else if (r == 8) bus.adr = 16'($urandom);
      else             bus.adr = 16'hC008 | 16'($urandom_range(0, 7));
      bus.writedata = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      evValid = ($urandom_range(0, 2) == 0);
      evData  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) sw = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder: the target end of the processor's memread/memwrite/adr/writedata data-memory interface, for the I/O space adr[15:14] == 2'b11.
- Provides an LED output register, synchronized switch inputs, a 4-entry input-event FIFO and a free-running timer with compare flag.
- Top level muxes iodata onto the processor's memdata whenever ioSel is high.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)
EV_WIDTH, 8, event payload bits (<= 16)
SW_WIDTH, 16, switch input bits (<= 16)

Ports:
clk  input  1  system clock
rst  input  1  reset
memread  input  1  processor read strobe
memwrite  input  1  processor write strobe
adr  input  16  processor data address
writedata  input  16  processor store data
iodata  output  16  read data to memdata mux
ioSel  output  1  high when adr[15:14] == 2'b11
sw  input  SW_WIDTH  raw asynchronous switches
evValid  input  1  single-cycle event push strobe
evData  input  EV_WIDTH  event payload
led  output  16  LED register

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst == 0 at a clk edge): led = 0, timer count = 0, compare = 0xFFFF, FIFO empty, overflow = 0, tflag = 0, sync flops = 0.
- ioSel and iodata are combinational from adr and current register state, with zero latency.
- iodata = 0 when ioSel == 0, when memread == 0, or for an unmapped offset.
- All register updates and side effects occur on the rising clk edge.
- Decode: selected = ioSel && adr[13:3] == 0. Register offset = adr[2:0].
- Register map:
  - 0 LED, RW. Write loads led.
  - 1 SW, RO. Two-flop synchronized sw, zero-extended to 16 bits.
  - 2 STATUS. Read: {12'b0, tflag, overflow, full, empty}. Writing 1 to bit 2 clears overflow; writing 1 to bit 3 clears tflag.
  - 3 EVENT, RO. Reads the FIFO head, zero-extended. A read pops the FIFO on the edge. Reading while empty returns 0 and pointers are unchanged.
  - 4 COUNT, RW. Write loads count.
  - 5 COMPARE, RW.
  - 6, 7 read 0; writes ignored.
- Writes to RO registers are ignored.
- memread and memwrite asserted together: the write takes effect and the read returns pre-write data. A pop still occurs if the offset is 3.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers, so full and empty are distinct. Pointers wrap modulo the depth.
  - evValid while not full: push.
  - evValid while full and no pop this cycle: data dropped, overflow set (sticky).
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: push only; the read returns 0.
- Timer:
  - count increments by 1 every cycle and wraps 0xFFFF -> 0x0000.
  - A COUNT write has priority over the increment.
  - tflag sets on the edge where the pre-increment count == compare.
  - If a set and a W1C clear of tflag occur in the same cycle, the set wins. The same rule applies to overflow.
- Reset mid-operation returns all state to reset values; an access during that cycle has no effect.

Optional Feature:
- Macro: IO_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and an IRQMASK register at offset 6 (RW, bits[1:0], reset 0).
  - irq is registered: irq <= (mask[0] & tflag) | (mask[1] & ~empty). It has one cycle of latency and resets to 0.
- Undefined: no irq port. Offset 6 reads 0 and writes are ignored.

Test Plan:
- Reset, then read offsets 0, 2, 5 -> iodata 0x0000, 0x0001, 0xFFFF; led = 0.
- Write 0xA5A5 to 0xC000, then read 0xC000 -> led and iodata = 0xA5A5. Read 0x8000 -> ioSel = 0, iodata = 0.
- Push 0x11, 0x22, 0x33, 0x44, then 0x55 -> STATUS = 0x0006 (full, overflow). Four EVENT reads return 0x11..0x44. STATUS then = 0x0005. A fifth EVENT read returns 0 with no pointer change.
- With the FIFO full, pulse evValid = 1 (0x66) in the same cycle as an EVENT read -> the read returns the head and overflow stays 0. Subsequent reads end with 0x66.
- Write COUNT = 0xFFFE and COMPARE = 0x0001 -> count wraps through 0x0000 and tflag = 1 after 4 edges. Write 0x0008 to STATUS -> tflag cleared. A clear issued on the exact set edge leaves tflag = 1.
- sw = 0x1234 applied -> the SW read returns 0x1234 from the second edge after the change, and the old value before that.
